// File: rtl/fec_encoder_stream.sv
// Streaming block encoder over the cyclic ring GF(2)[x]/(x^WIDTH - 1).
// A block of M data symbols is latched together with its N x M coefficient
// matrix, then N coded symbols are emitted one per output handshake.

// Cyclic product a*b, returning only the low OUT_W bits of the WIDTH-bit result.
module fec_cyc_mul #(
    parameter int WIDTH = 11,
    parameter int OUT_W = WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [OUT_W-1:0] p
);
    // bit k collects every a[i]*b[j] with (i + j) mod WIDTH == k
    always_comb begin
        p = '0;
        for (int k = 0; k < OUT_W; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                p[k] = p[k] ^ (a[i] & b[(k - i + WIDTH) % WIDTH]);
            end
        end
    end
endmodule

module fec_encoder_stream #(
    parameter int M      = 3,
    parameter int N      = 5,
    parameter int WIDTH  = 11,
    parameter int DATA_W = WIDTH - 1,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [M-1:0][DATA_W-1:0]           in_symbols,
    input  logic [N-1:0][M-1:0][WIDTH-1:0]     encode_coeffs,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  out_symbol,
    output logic [IW-1:0]                      out_index,
    output logic                               out_last
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  row_q, row_d;
    logic [M-1:0][WIDTH-1:0]        sym_q;
    logic [N-1:0][M-1:0][WIDTH-1:0] coeff_q;
    logic [M-1:0][DATA_W-1:0]       prod;
    logic [DATA_W-1:0]              row_res;
    logic                           in_hs, out_hs, at_last;

    assign in_ready = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign in_hs = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign at_last = (row_q == IW'(N - 1));

    // state and row counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // IDLE waits for a block; EMIT walks rows 0..N-1 on output handshakes
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                row_d = '0;
                if (in_hs) state_d = EMIT;
            end
            EMIT: begin
                if (out_hs) begin
                    if (at_last) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    // capture the block on accept; symbols are lifted with even parity in the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_q   <= '0;
            coeff_q <= '0;
        end else if (in_hs) begin
            for (int j = 0; j < M; j++) begin
                sym_q[j] <= WIDTH'({^in_symbols[j], in_symbols[j]});
            end
            coeff_q <= encode_coeffs;
        end
    end

    // one cyclic multiplier per data symbol for the currently selected row;
    // the MSB is never computed since it is just the parity of the low bits
    for (genvar j = 0; j < M; j++) begin : g_mul
        fec_cyc_mul #(.WIDTH(WIDTH), .OUT_W(DATA_W)) u_mul (
            .a (coeff_q[row_q][j]),
            .b (sym_q[j]),
            .p (prod[j])
        );
    end

    // sum of the per-symbol products for this row
    always_comb begin
        row_res = '0;
        for (int j = 0; j < M; j++) begin
            row_res = row_res ^ prod[j];
        end
    end

    assign out_symbol = out_valid ? row_res : '0;
    assign out_index  = out_valid ? row_q : '0;
    assign out_last   = out_valid && at_last;
endmodule

// File: tb/tb_fec_encoder_stream.sv
// Bench for fec_encoder_stream: directed scenarios plus randomized blocks,
// all checked by a cyclic-polynomial reference model and a beat scoreboard.
module tb_fec_encoder_stream;
    localparam int M  = 3;
    localparam int N  = 5;
    localparam int W  = 11;
    localparam int DW = W - 1;
    localparam int IW = 3;

    typedef logic [M-1:0][DW-1:0]       syms_t;
    typedef logic [N-1:0][M-1:0][W-1:0] coeffs_t;
    typedef struct {
        logic [DW-1:0] sym;
        logic [IW-1:0] idx;
        logic          last;
        logic [W-1:0]  full;
    } beat_t;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_ready;
    syms_t         in_symbols = '0;
    coeffs_t       encode_coeffs = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_symbol;
    logic [IW-1:0] out_index;
    logic          out_last;

    logic rand_mode = 0;
    logic man_ready = 1;
    logic rnd_ready = 1;
    assign out_ready = rand_mode ? rnd_ready : man_ready;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int beats = 0;
    beat_t exp_q[$];
    int acc_cyc[$];
    int last_cyc[$];

    fec_encoder_stream #(.M(M), .N(N), .WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_symbols    (in_symbols),
        .encode_coeffs (encode_coeffs),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_symbol    (out_symbol),
        .out_index     (out_index),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---- reference model: polynomial arithmetic modulo x^W - 1 ----
    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int s);
        return (v << s) | (v >> (W - s));
    endfunction

    function automatic logic [W-1:0] cmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] acc = '0;
        for (int i = 0; i < W; i++) if (a[i]) acc ^= rotl(b, i);
        return acc;
    endfunction

    function automatic logic [W-1:0] lift(input logic [DW-1:0] s);
        return {^s, s};
    endfunction

    function automatic logic [W-1:0] model_row(input syms_t s, input coeffs_t c, input int r);
        logic [W-1:0] acc = '0;
        for (int j = 0; j < M; j++) acc ^= cmul(c[r][j], lift(s[j]));
        return acc;
    endfunction

    // ---- compare process: every cycle, sampled on the falling edge ----
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_symbol", out_symbol, 0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_last", out_last, 0);
        end else begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() == 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_symbol", out_symbol, exp_q[0].sym);
                chk("out_index", out_index, exp_q[0].idx);
                chk("out_last", out_last, exp_q[0].last);
                chk("row_parity", ^exp_q[0].full, 0);
                if (out_ready) begin
                    if (out_last) last_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                    beats++;
                end
            end else if (!out_valid) begin
                chk("idle_symbol", out_symbol, 0);
                chk("idle_index", out_index, 0);
                chk("idle_last", out_last, 0);
            end
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                for (int r = 0; r < N; r++) begin
                    beat_t b;
                    b.full = model_row(in_symbols, encode_coeffs, r);
                    b.sym  = b.full[DW-1:0];
                    b.idx  = IW'(r);
                    b.last = (r == N - 1);
                    exp_q.push_back(b);
                end
            end
        end
    end

    // offer a block and wait (bounded) for it to be accepted
    task automatic send_block(input syms_t s, input coeffs_t c, input bit keep);
        int n = 0;
        bit hs = 0;
        in_symbols = s;
        encode_coeffs = c;
        in_valid = 1;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!keep) in_valid = 0;
        chk("accept_timeout", hs, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", n < 300, 1);
    endtask

    function automatic coeffs_t rand_coeffs();
        coeffs_t c;
        for (int r = 0; r < N; r++)
            for (int j = 0; j < M; j++)
                c[r][j] = W'($urandom);
        if ($urandom_range(0, 7) == 0) c = '0;
        return c;
    endfunction

    function automatic syms_t rand_syms();
        syms_t s;
        for (int j = 0; j < M; j++) s[j] = DW'($urandom);
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        syms_t   d_syms;
        coeffs_t d_coeffs;
        int      b0;

        // directed block: identity rows 0-2, x in row 3, zero row 4
        d_syms = '0;
        d_syms[0] = 10'h001;
        d_syms[1] = 10'h003;
        d_coeffs = '0;
        for (int j = 0; j < M; j++) begin
            d_coeffs[j][j] = 11'h001;
            d_coeffs[3][j] = 11'h002;
        end

        // hand-computed pins of the model itself
        chk("model_lift", lift(10'h001), 11'h401);
        chk("model_cmul_wrap", cmul(11'h002, 11'h401), 11'h003);
        chk("model_row0", model_row(d_syms, d_coeffs, 0), 11'h401);
        chk("model_row1", model_row(d_syms, d_coeffs, 1) & 11'h3ff, 10'h003);
        chk("model_row2", model_row(d_syms, d_coeffs, 2), 11'h000);
        chk("model_row3", model_row(d_syms, d_coeffs, 3), 11'h005);
        chk("model_row4", model_row(d_syms, d_coeffs, 4), 11'h000);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        rst_n = 1;
        @(posedge clk);
        #1;

        // basic block, sink always ready: first beat one cycle after accept
        man_ready = 1;
        send_block(d_syms, d_coeffs, 0);
        chk("lat_valid", out_valid, 1);
        chk("lat_symbol", out_symbol, 10'h001);
        wait_drain();

        // backpressure at index 2
        b0 = beats;
        send_block(d_syms, d_coeffs, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        man_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_index", out_index, 2);
            chk("stall_symbol", out_symbol, 10'h000);
            chk("stall_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        chk("stall_index_after", out_index, 2);
        man_ready = 1;
        wait_drain();
        chk("stall_beat_count", beats - b0, 5);

        // reset after the index-1 handshake
        send_block(d_syms, d_coeffs, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_reset_index", out_index, 2);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_index", out_index, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        b0 = beats;
        repeat (6) @(posedge clk);
        #1;
        chk("post_reset_no_beats", beats - b0, 0);
        chk("post_reset_valid", out_valid, 0);

        // back-to-back blocks with in_valid held high
        acc_cyc.delete();
        last_cyc.delete();
        send_block(d_syms, d_coeffs, 1);
        send_block(rand_syms(), rand_coeffs(), 0);
        wait_drain();
        chk("b2b_accepts", acc_cyc.size(), 2);
        chk("b2b_lasts", last_cyc.size(), 2);
        if (acc_cyc.size() == 2 && last_cyc.size() == 2) begin
            chk("b2b_second_accept", acc_cyc[1] - acc_cyc[0], 6);
            chk("b2b_second_last", last_cyc[1] - acc_cyc[0], 11);
        end

        // random blocks, random sink readiness, inputs churning every cycle
        rand_mode = 1;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 2) != 0);
            in_symbols = rand_syms();
            encode_coeffs = rand_coeffs();
        end
        in_valid = 0;
        rand_mode = 0;
        man_ready = 1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
